// File: rtl/uart_rx_frame_ctrl.sv
// Frame-level receive controller: SOF/LEN/payload/XOR-checksum framing,
// buffered payload release on a valid/ready stream, fault flags and counters.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SOF_BYTE    = 8'h7E,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 52080
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        rx_parity_error,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [2:0]  err_code,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] MAXL = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAY,
    S_CSUM,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [7:0]    len_q;
  logic [7:0]    csum_q;
  logic [7:0]    wr_idx_q;
  logic [7:0]    rd_idx_q;
  logic [TW-1:0] gap_q;
  logic [7:0]    buf_mem [MAX_LEN];

  logic       in_frame;
  logic       take;
  logic       len_bad;
  logic [2:0] fault;
  logic       ev_ok;
  logic       ev_err;
  logic [2:0] ev_code;

  assign in_frame = (state_q == S_LEN) ||
                    (state_q == S_PAY) ||
                    (state_q == S_CSUM);
  assign take     = rx_valid && !rx_parity_error;
  assign len_bad  = (rx_byte == 8'd0) || (rx_byte > MAXL);

  // Parity beats a same-cycle byte; a same-cycle byte beats timeout.
  always_comb begin
    fault = 3'd0;
    if (rx_parity_error)
      fault = 3'd1;
    else if (!rx_valid && gap_q == T_LAST)
      fault = 3'd4;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ev_ok   = 1'b0;
    ev_err  = 1'b0;
    ev_code = 3'd0;
    unique case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_byte == SOF_BYTE)
          state_d = S_LEN;
      end
      S_LEN, S_PAY, S_CSUM: begin
        if (fault != 3'd0) begin
          ev_err  = 1'b1;
          ev_code = fault;
          state_d = S_IDLE;
        end else if (rx_valid) begin
          unique case (state_q)
            S_LEN: begin
              if (len_bad) begin
                ev_err  = 1'b1;
                ev_code = 3'd2;
                state_d = S_IDLE;
              end else begin
                state_d = S_PAY;
              end
            end
            S_PAY: begin
              if (wr_idx_q == len_q - 8'd1)
                state_d = S_CSUM;
            end
            default: begin
              if (rx_byte == csum_q) begin
                ev_ok   = 1'b1;
                state_d = S_DRAIN;
              end else begin
                ev_err  = 1'b1;
                ev_code = 3'd3;
                state_d = S_IDLE;
              end
            end
          endcase
        end
      end
      S_DRAIN: begin
        if (rx_valid) begin
          ev_err  = 1'b1;
          ev_code = 3'd5;
        end
        if (out_ready && out_last)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == S_DRAIN);
    out_data  = 8'd0;
    out_last  = 1'b0;
    busy      = (state_q != S_IDLE);
    if (out_valid) begin
      out_data = buf_mem[rd_idx_q[IW-1:0]];
      out_last = (rd_idx_q == len_q - 8'd1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q    <= 8'd0;
      csum_q   <= 8'd0;
      wr_idx_q <= 8'd0;
      rd_idx_q <= 8'd0;
      gap_q    <= '0;
    end else begin
      if (in_frame && !rx_valid)
        gap_q <= gap_q + TW'(1);
      else
        gap_q <= '0;
      if (state_q == S_LEN && take) begin
        len_q    <= rx_byte;
        csum_q   <= rx_byte;
        wr_idx_q <= 8'd0;
      end
      if (state_q == S_PAY && take) begin
        csum_q   <= csum_q ^ rx_byte;
        wr_idx_q <= wr_idx_q + 8'd1;
      end
      if (state_q != S_DRAIN)
        rd_idx_q <= 8'd0;
      else if (out_ready)
        rd_idx_q <= rd_idx_q + 8'd1;
    end
  end

  // Payload storage needs no reset; contents are only read after a full frame.
  always_ff @(posedge clk) begin
    if (state_q == S_PAY && take)
      buf_mem[wr_idx_q[IW-1:0]] <= rx_byte;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 3'd0;
      frame_cnt <= 16'd0;
      err_cnt   <= 16'd0;
    end else begin
      frame_ok  <= ev_ok;
      frame_err <= ev_err;
      err_code  <= ev_code;
      if (ev_ok && frame_cnt != 16'hFFFF)
        frame_cnt <= frame_cnt + 16'd1;
      if (ev_err && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: directed frames, expected
// payload beats and frame events queued up front, checked by a monitor.
`timescale 1ns/1ps
module tb_uart_rx_frame_ctrl;

  localparam int MAXL = 16;
  localparam int TMO  = 200;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'd0;
  logic        rx_parity_error = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        frame_ok;
  logic        frame_err;
  logic [2:0]  err_code;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  uart_rx_frame_ctrl #(
    .SOF_BYTE(8'h7E),
    .MAX_LEN(MAXL),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rx_valid(rx_valid),
    .rx_byte(rx_byte),
    .rx_parity_error(rx_parity_error),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_last(out_last),
    .out_ready(out_ready),
    .frame_ok(frame_ok),
    .frame_err(frame_err),
    .err_code(err_code),
    .busy(busy),
    .frame_cnt(frame_cnt),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_out[$];
  int         exp_ev[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Event code 0 = frame_ok, 1..5 = frame_err cause, 8 = both at once.
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_extra: got %0h want none", {out_last, out_data});
        end else begin
          check("out_beat", {23'd0, out_last, out_data}, {23'd0, exp_out.pop_front()});
        end
      end
      if (frame_ok || frame_err) begin
        logic [31:0] ev;
        ev = (frame_ok && frame_err) ? 32'd8 :
             frame_ok ? 32'd0 : {29'd0, err_code};
        if (exp_ev.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL event_extra: got %0d want none", ev);
        end else begin
          check("event", ev, exp_ev.pop_front());
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic pe);
    rx_valid = 1'b1;
    rx_byte = b;
    rx_parity_error = pe;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_parity_error = 1'b0;
  endtask

  task automatic send_seq(input bq_t s);
    foreach (s[i]) send_byte(s[i], 1'b0);
  endtask

  task automatic expect_payload(input bq_t p);
    foreach (p[i]) exp_out.push_back({(i == p.size() - 1), p[i]});
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 300; n++) begin
      if (exp_out.size() == 0 && exp_ev.size() == 0) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check("sb_empty", exp_out.size() + exp_ev.size(), 0);
  endtask

  initial begin
    int n;
    #12;
    check("rst_outs", {out_valid, out_data, out_last, frame_ok, frame_err,
                       err_code, busy}, 0);
    check("rst_cnts", {frame_cnt, err_cnt}, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: good frame, checksum 03^11^22^33 = 03
    out_ready = 1'b1;
    expect_payload('{8'h11, 8'h22, 8'h33});
    exp_ev.push_back(0);
    send_seq('{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
    for (int i = 0; i < 3; i++) begin
      check("t1_streak", out_valid, 1);
      @(posedge clk); #1;
    end
    check("t1_valid_low", out_valid, 0);
    check("t1_frame_cnt", frame_cnt, 1);
    wait_drain();

    // 2: bad checksum, then a good frame still delivers
    exp_ev.push_back(3);
    send_seq('{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00});
    check("t2_idle", busy, 0);
    wait_drain();
    check("t2_err_cnt", err_cnt, 1);
    check("t2_no_out", out_valid, 0);
    expect_payload('{8'h11, 8'h22, 8'h33});
    exp_ev.push_back(0);
    send_seq('{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
    wait_drain();
    check("t2_frame_cnt", frame_cnt, 2);

    // 3: zero length and MAX_LEN+1
    exp_ev.push_back(2);
    send_seq('{8'h7E, 8'h00});
    check("t3_idle_a", busy, 0);
    exp_ev.push_back(2);
    send_seq('{8'h7E, 8'(MAXL + 1)});
    check("t3_idle_b", busy, 0);
    wait_drain();
    check("t3_err_cnt", err_cnt, 3);

    // 4: inter-byte timeout
    exp_ev.push_back(4);
    send_seq('{8'h7E, 8'h02, 8'hAA});
    n = 0;
    for (int i = 1; i <= TMO + 20; i++) begin
      @(posedge clk); #1;
      if (frame_err) begin
        n = i;
        break;
      end
    end
    check("t4_tmo_cycles", n, TMO);
    check("t4_idle", busy, 0);
    wait_drain();
    expect_payload('{8'h55});
    exp_ev.push_back(0);
    send_seq('{8'h7E, 8'h01, 8'h55, 8'h54});
    wait_drain();

    // 5: stalled consumer with overrun
    out_ready = 1'b0;
    exp_ev.push_back(0);
    send_seq('{8'h7E, 8'h02, 8'hA5, 8'h5A, 8'hFD});
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        exp_ev.push_back(5);
        send_byte(8'h7E, 1'b0);
      end else begin
        @(posedge clk); #1;
      end
      check("t5_hold", {out_valid, out_last, out_data}, {2'b10, 8'hA5});
    end
    check("t5_busy", busy, 1);
    expect_payload('{8'hA5, 8'h5A});
    out_ready = 1'b1;
    wait_drain();
    check("t5_cnts", {frame_cnt, err_cnt}, {16'd4, 16'd5});

    // 6: parity on second payload byte
    exp_ev.push_back(1);
    send_byte(8'h7E, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b1);
    check("t6_idle", busy, 0);
    wait_drain();
    check("t6_err_cnt", err_cnt, 6);

    // 6b: async reset in DRAIN
    out_ready = 1'b0;
    exp_ev.push_back(0);
    send_seq('{8'h7E, 8'h02, 8'h01, 8'h02, 8'h01});
    @(posedge clk); #1;
    check("t6_in_drain", out_valid, 1);
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_rst_outs", {out_valid, out_data, out_last, frame_ok, frame_err,
                          err_code, busy}, 0);
    check("t6_rst_cnts", {frame_cnt, err_cnt}, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t6_after_rst", out_valid, 0);
    expect_payload('{8'h11, 8'h22, 8'h33});
    exp_ev.push_back(0);
    send_seq('{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
    wait_drain();
    check("t6_frame_cnt", frame_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
